// File: rtl/accum_flag_regs.sv
// Accumulator A/B write-back stage with N/Z/C flag registers and branch evaluation.
// Optional A<->B exchange on iSwap is built only when ACCUM_SWAP_EN is defined.
module accum_flag_regs #(
    parameter int                WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = 8'h00
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] iALUOut,
    input  logic             iN_A,
    input  logic             iZ_A,
    input  logic             iC_A,
    input  logic             iN_B,
    input  logic             iZ_B,
    input  logic             iC_B,
    input  logic             iRegOutputALU,
    input  logic             iWriteALU,
    input  logic             iCompare,
    input  logic             iLoadData,
    input  logic             iLoadSel,
    input  logic [WIDTH-1:0] iData,
    input  logic             iSwap,
    input  logic [2:0]       iBranchCond,
    output logic [WIDTH-1:0] oA,
    output logic [WIDTH-1:0] oB,
    output logic [2:0]       oFlagsA,
    output logic [2:0]       oFlagsB,
    output logic             oBranchTaken
);

    logic [WIDTH-1:0] a_r, b_r, a_nxt_s, b_nxt_s;
    logic [2:0]       fa_r, fb_r, fa_nxt_s, fb_nxt_s;
    logic             upd_s, upd_a_s, upd_b_s, wr_a_s, wr_b_s;
    logic             load_a_s, load_b_s, ld_n_s, ld_z_s, swap_s;

    assign upd_s    = iWriteALU | iCompare;
    assign upd_a_s  = upd_s & ~iRegOutputALU;
    assign upd_b_s  = upd_s & iRegOutputALU;
    assign wr_a_s   = iWriteALU & ~iRegOutputALU;
    assign wr_b_s   = iWriteALU & iRegOutputALU;
    assign load_a_s = iLoadData & ~iLoadSel;
    assign load_b_s = iLoadData & iLoadSel;
    assign ld_n_s   = iData[WIDTH-1];
    assign ld_z_s   = (iData == {WIDTH{1'b0}});

`ifdef ACCUM_SWAP_EN
    // Exchange only when no other strobe competes for the registers.
    assign swap_s = iSwap & ~upd_s & ~iLoadData;
`else
    logic swap_unused_s;
    assign swap_unused_s = iSwap;
    assign swap_s        = 1'b0;
`endif

    // Next-state: a load overrides data and N/Z of its target but keeps that target's C.
    always_comb begin
        a_nxt_s  = load_a_s ? iData : (wr_a_s ? iALUOut : (swap_s ? b_r : a_r));
        b_nxt_s  = load_b_s ? iData : (wr_b_s ? iALUOut : (swap_s ? a_r : b_r));
        fa_nxt_s = load_a_s ? {ld_n_s, ld_z_s, fa_r[0]}
                 : (upd_a_s ? {iN_A, iZ_A, iC_A} : (swap_s ? fb_r : fa_r));
        fb_nxt_s = load_b_s ? {ld_n_s, ld_z_s, fb_r[0]}
                 : (upd_b_s ? {iN_B, iZ_B, iC_B} : (swap_s ? fa_r : fb_r));
    end

    // Accumulator and flag registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            a_r  <= RESET_VAL;
            b_r  <= RESET_VAL;
            fa_r <= 3'b000;
            fb_r <= 3'b000;
        end else begin
            a_r  <= a_nxt_s;
            b_r  <= b_nxt_s;
            fa_r <= fa_nxt_s;
            fb_r <= fb_nxt_s;
        end
    end

    // Branch condition decode from registered flags ({N,Z,C} ordering).
    always_comb begin
        oBranchTaken = 1'b0;
        case (iBranchCond)
            3'd0:    oBranchTaken = 1'b1;
            3'd1:    oBranchTaken = fa_r[1];
            3'd2:    oBranchTaken = ~fa_r[1];
            3'd3:    oBranchTaken = fa_r[0];
            3'd4:    oBranchTaken = fa_r[2];
            3'd5:    oBranchTaken = fb_r[1];
            3'd6:    oBranchTaken = fb_r[0];
            3'd7:    oBranchTaken = fb_r[2];
            default: oBranchTaken = 1'b0;
        endcase
    end

    assign oA      = a_r;
    assign oB      = b_r;
    assign oFlagsA = fa_r;
    assign oFlagsB = fb_r;

endmodule

// File: tb/tb_accum_flag_regs.sv
// Self-checking bench for accum_flag_regs: directed scenarios plus randomized traffic
// checked against an array-based model of the two accumulators.
module tb_accum_flag_regs;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] iALUOut = 8'h00, iData = 8'h00;
    logic       iN_A = 1'b0, iZ_A = 1'b0, iC_A = 1'b0, iN_B = 1'b0, iZ_B = 1'b0, iC_B = 1'b0;
    logic       iRegOutputALU = 1'b0, iWriteALU = 1'b0, iCompare = 1'b0;
    logic       iLoadData = 1'b0, iLoadSel = 1'b0, iSwap = 1'b0;
    logic [2:0] iBranchCond = 3'd0;
    logic [7:0] oA, oB;
    logic [2:0] oFlagsA, oFlagsB;
    logic       oBranchTaken;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: index 0 = A, 1 = B; flags stored as {N,Z,C}.
    logic [7:0] m_val [2];
    logic [2:0] m_f   [2];

    accum_flag_regs dut (
        .Clock(Clock), .Reset(Reset), .iALUOut(iALUOut),
        .iN_A(iN_A), .iZ_A(iZ_A), .iC_A(iC_A), .iN_B(iN_B), .iZ_B(iZ_B), .iC_B(iC_B),
        .iRegOutputALU(iRegOutputALU), .iWriteALU(iWriteALU), .iCompare(iCompare),
        .iLoadData(iLoadData), .iLoadSel(iLoadSel), .iData(iData), .iSwap(iSwap),
        .iBranchCond(iBranchCond), .oA(oA), .oB(oB), .oFlagsA(oFlagsA), .oFlagsB(oFlagsB),
        .oBranchTaken(oBranchTaken)
    );

    always #5 Clock = ~Clock;

    function automatic logic exp_branch(input logic [2:0] cond);
        case (cond)
            3'd0:    return 1'b1;
            3'd1:    return m_f[0][1];
            3'd2:    return !m_f[0][1];
            3'd3:    return m_f[0][0];
            3'd4:    return m_f[0][2];
            3'd5:    return m_f[1][1];
            3'd6:    return m_f[1][0];
            3'd7:    return m_f[1][2];
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_val[i] = 8'h00;
            m_f[i]   = 3'b000;
        end
    endtask

    // Drive one cycle of strobes, advance the model, and leave outputs settled after the edge.
    task automatic apply(input logic we, input logic cmp, input logic sel, input logic ld,
                         input logic lsel, input logic sw, input logic [7:0] alu,
                         input logic [7:0] data, input logic [2:0] fa, input logic [2:0] fb);
        logic [2:0] old_f [2];
        @(negedge Clock);
        iWriteALU = we; iCompare = cmp; iRegOutputALU = sel; iLoadData = ld; iLoadSel = lsel;
        iSwap = sw; iALUOut = alu; iData = data;
        {iN_A, iZ_A, iC_A} = fa;
        {iN_B, iZ_B, iC_B} = fb;
        @(posedge Clock);
        old_f[0] = m_f[0];
        old_f[1] = m_f[1];
        if (we || cmp) begin
            m_f[sel] = sel ? fb : fa;
            if (we) m_val[sel] = alu;
        end
        if (ld) begin
            m_val[lsel] = data;
            m_f[lsel]   = {data[7], data == 8'h00, old_f[lsel][0]};
        end
`ifdef ACCUM_SWAP_EN
        if (sw && !we && !cmp && !ld) begin
            {m_val[0], m_val[1]} = {m_val[1], m_val[0]};
            {m_f[0], m_f[1]}     = {m_f[1], m_f[0]};
        end
`endif
        #1;
        iWriteALU = 1'b0; iCompare = 1'b0; iLoadData = 1'b0; iSwap = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        #1;
        n_checks++; if (oA !== 8'h00) begin n_fail++; $display("FAIL reset_a got %h exp 00", oA); end
        n_checks++; if (oB !== 8'h00) begin n_fail++; $display("FAIL reset_b got %h exp 00", oB); end
        n_checks++; if ({oFlagsA, oFlagsB} !== 6'b000000) begin n_fail++; $display("FAIL reset_flags got %b%b exp 000000", oFlagsA, oFlagsB); end
        iBranchCond = 3'd0; #1;
        n_checks++; if (oBranchTaken !== 1'b1) begin n_fail++; $display("FAIL reset_br0 got %b exp 1", oBranchTaken); end
        iBranchCond = 3'd2; #1;
        n_checks++; if (oBranchTaken !== 1'b1) begin n_fail++; $display("FAIL reset_br2 got %b exp 1", oBranchTaken); end
        iBranchCond = 3'd3; #1;
        n_checks++; if (oBranchTaken !== 1'b0) begin n_fail++; $display("FAIL reset_br3 got %b exp 0", oBranchTaken); end
        @(negedge Clock);
        Reset = 1'b1;
        model_reset();
    endtask

    task automatic test_alu_write();
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hAA, 3'b011, 3'b111);
        n_checks++; if (oA !== 8'h00) begin n_fail++; $display("FAIL wr_a got %h exp 00", oA); end
        n_checks++; if (oFlagsA !== 3'b011) begin n_fail++; $display("FAIL wr_fa got %b exp 011", oFlagsA); end
        n_checks++; if ({oB, oFlagsB} !== 11'h000) begin n_fail++; $display("FAIL wr_b_hold got %h/%b exp 00/000", oB, oFlagsB); end
        iBranchCond = 3'd1; #1;
        n_checks++; if (oBranchTaken !== 1'b1) begin n_fail++; $display("FAIL wr_br1 got %b exp 1", oBranchTaken); end
        iBranchCond = 3'd3; #1;
        n_checks++; if (oBranchTaken !== 1'b1) begin n_fail++; $display("FAIL wr_br3 got %b exp 1", oBranchTaken); end
        apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h9C, 8'h00, 3'b000, 3'b100);
        n_checks++; if ({oA, oB, oFlagsB} !== {8'h00, 8'h9C, 3'b100}) begin n_fail++; $display("FAIL wr_b got %h %h %b exp 00 9c 100", oA, oB, oFlagsB); end
    endtask

    task automatic test_load();
        apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'b000, 3'b001);
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h80, 3'b000, 3'b000);
        n_checks++; if (oB !== 8'h80) begin n_fail++; $display("FAIL ld_b got %h exp 80", oB); end
        n_checks++; if (oFlagsB !== 3'b101) begin n_fail++; $display("FAIL ld_fb got %b exp 101", oFlagsB); end
        iBranchCond = 3'd7; #1;
        n_checks++; if (oBranchTaken !== 1'b1) begin n_fail++; $display("FAIL ld_br7 got %b exp 1", oBranchTaken); end
        iBranchCond = 3'd5; #1;
        n_checks++; if (oBranchTaken !== 1'b0) begin n_fail++; $display("FAIL ld_br5 got %b exp 0", oBranchTaken); end
    endtask

    task automatic test_compare();
        apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3'b111, 3'b010);
        n_checks++; if (oB !== 8'h80) begin n_fail++; $display("FAIL cmp_b got %h exp 80", oB); end
        n_checks++; if (oFlagsB !== 3'b010) begin n_fail++; $display("FAIL cmp_fb got %b exp 010", oFlagsB); end
        n_checks++; if (oFlagsA !== 3'b011) begin n_fail++; $display("FAIL cmp_fa_hold got %b exp 011", oFlagsA); end
    endtask

    task automatic test_collision();
        apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h12, 8'h34, 3'b110, 3'b000);
        n_checks++; if (oA !== 8'h34) begin n_fail++; $display("FAIL col_same_a got %h exp 34", oA); end
        n_checks++; if (oFlagsA !== 3'b001) begin n_fail++; $display("FAIL col_same_fa got %b exp 001", oFlagsA); end
        apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h12, 8'h34, 3'b100, 3'b000);
        n_checks++; if ({oA, oB} !== 16'h1234) begin n_fail++; $display("FAIL col_diff got %h%h exp 1234", oA, oB); end
        n_checks++; if ({oFlagsA, oFlagsB} !== 6'b100000) begin n_fail++; $display("FAIL col_diff_f got %b%b exp 100000", oFlagsA, oFlagsB); end
    endtask

    task automatic test_reset_mid();
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h55, 3'b000, 3'b000);
        @(negedge Clock);
        iLoadData = 1'b1; iLoadSel = 1'b1; iData = 8'h77;
        #2 Reset = 1'b0;
        #1;
        n_checks++; if ({oA, oB} !== 16'h0000) begin n_fail++; $display("FAIL midrst got %h%h exp 0000", oA, oB); end
        n_checks++; if ({oFlagsA, oFlagsB} !== 6'b000000) begin n_fail++; $display("FAIL midrst_f got %b%b exp 000000", oFlagsA, oFlagsB); end
        iBranchCond = 3'd0; #1;
        n_checks++; if (oBranchTaken !== 1'b1) begin n_fail++; $display("FAIL midrst_br0 got %b exp 1", oBranchTaken); end
        @(posedge Clock); #1;
        n_checks++; if (oB !== 8'h00) begin n_fail++; $display("FAIL midrst_lost got %h exp 00", oB); end
        @(negedge Clock);
        iLoadData = 1'b0;
        Reset = 1'b1;
        model_reset();
    endtask

    task automatic test_swap();
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 3'b000, 3'b000);
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'hF0, 3'b000, 3'b000);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 3'b000, 3'b000);
`ifdef ACCUM_SWAP_EN
        n_checks++; if ({oA, oFlagsA, oB, oFlagsB} !== {8'hF0, 3'b100, 8'h01, 3'b000}) begin n_fail++; $display("FAIL swap got %h/%b %h/%b exp f0/100 01/000", oA, oFlagsA, oB, oFlagsB); end
`else
        n_checks++; if ({oA, oFlagsA, oB, oFlagsB} !== {8'h01, 3'b000, 8'hF0, 3'b100}) begin n_fail++; $display("FAIL noswap got %h/%b %h/%b exp 01/000 f0/100", oA, oFlagsA, oB, oFlagsB); end
`endif
        apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 8'h00, 3'b000, 3'b001);
        n_checks++; if ({oA, oB} !== {m_val[0], m_val[1]}) begin n_fail++; $display("FAIL swap_with_wr got %h%h exp %h%h", oA, oB, m_val[0], m_val[1]); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            iBranchCond = 3'($urandom_range(0, 7));
            apply(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                  1'($urandom), 1'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                  3'($urandom), 3'($urandom));
            n_checks++; if (oA !== m_val[0]) begin n_fail++; $display("FAIL rnd_a it%0d got %h exp %h", i, oA, m_val[0]); end
            n_checks++; if (oB !== m_val[1]) begin n_fail++; $display("FAIL rnd_b it%0d got %h exp %h", i, oB, m_val[1]); end
            n_checks++; if (oFlagsA !== m_f[0]) begin n_fail++; $display("FAIL rnd_fa it%0d got %b exp %b", i, oFlagsA, m_f[0]); end
            n_checks++; if (oFlagsB !== m_f[1]) begin n_fail++; $display("FAIL rnd_fb it%0d got %b exp %b", i, oFlagsB, m_f[1]); end
            n_checks++; if (oBranchTaken !== exp_branch(iBranchCond)) begin n_fail++; $display("FAIL rnd_br it%0d cond %0d got %b exp %b", i, iBranchCond, oBranchTaken, exp_branch(iBranchCond)); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_alu_write();
        test_load();
        test_compare();
        test_collision();
        test_reset_mid();
        test_swap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
